aoa_resolver_seq: RTL and testbench

- Time-multiplexed angle-of-arrival resolver. It accepts four sensor delay codes (x1, x2, y1, y2) over a valid/ready handshake.
- It looks each code up in sequence through one shared external angle LUT.
- It resolves the quadrant into a 0..359 degree bearing, with a programmable in-range window, modulo-360 wrap, miss tracking and an optional hold-last-valid mode.
- It sits between the delay-code capture stage and the bearing consumer, and replaces four parallel LUT instances with one.

---
 rtl/aoa_resolver_seq.sv | 170 +++++++++++++++++
 tb/tb_aoa_resolver_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aoa_resolver_seq.sv
// Angle-of-arrival resolver: four delay codes looked up through one
// shared LUT, resolved into a 0..359 degree bearing.
module aoa_resolver_seq #(
  parameter int CODE_W    = 8,
  parameter int ANG_W     = 8,
  parameter int OUT_W     = 9,
  parameter int WIN_LO    = 40,
  parameter int WIN_HI    = 90,
  parameter int LUT_LAT   = 1,
  parameter int HOLD_LAST = 0,
  parameter int MISS_W    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*CODE_W-1:0] in_codes,
  output logic [CODE_W-1:0]   lut_code,
  input  logic [ANG_W-1:0]    lut_theta,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_theta,
  output logic                out_miss,
  output logic                out_stale,
  output logic [MISS_W-1:0]   miss_count
);

  localparam int W = OUT_W + 1;
  localparam logic [W-1:0] C90  = W'(90);
  localparam logic [W-1:0] C180 = W'(180);
  localparam logic [W-1:0] C270 = W'(270);
  localparam logic [W-1:0] C360 = W'(360);
  localparam logic [W-1:0] C450 = W'(450);
  localparam logic [W-1:0] C540 = W'(540);
  localparam logic [ANG_W-1:0] LO = ANG_W'(WIN_LO);
  localparam logic [ANG_W-1:0] HI = ANG_W'(WIN_HI);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WAIT, RESOLVE, OUTPUT
  } state_t;

  state_t state, state_nx;

  logic [CODE_W-1:0] code_q [4];
  logic [ANG_W-1:0]  ang_q  [4];
  logic [1:0]        iss_idx;
  logic [1:0]        ret_idx;
  logic [LUT_LAT-1:0] pend;
  logic [OUT_W-1:0]  last_q;
  logic              cap;
  logic              accept;

  logic [3:0]   in_win;
  logic [3:0]   sel;
  logic         hit;
  logic         x_pos;
  logic         y_pos;
  logic [W-1:0] a0, a1, a2, a3;
  logic [W-1:0] raw;
  logic [W-1:0] wrap;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign cap       = pend[LUT_LAT-1];
  assign lut_code  = code_q[iss_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = LOOKUP;
      LOOKUP:  if (iss_idx == 2'd3) state_nx = WAIT;
      WAIT:    if (cap && ret_idx == 2'd3) state_nx = RESOLVE;
      RESOLVE: state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue side walks the codes; return side follows LUT_LAT behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        code_q[k] <= '0;
        ang_q[k]  <= '0;
      end
      iss_idx <= '0;
      ret_idx <= '0;
      pend    <= '0;
    end else begin
      pend[0] <= (state == LOOKUP);
      for (int i = 1; i < LUT_LAT; i++)
        pend[i] <= pend[i-1];
      if (accept) begin
        for (int k = 0; k < 4; k++)
          code_q[k] <= in_codes[k*CODE_W +: CODE_W];
        iss_idx <= '0;
        ret_idx <= '0;
      end else begin
        if (state == LOOKUP && iss_idx != 2'd3)
          iss_idx <= iss_idx + 2'd1;
        if (cap) begin
          ang_q[ret_idx] <= lut_theta;
          ret_idx        <= ret_idx + 2'd1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      in_win[k] = (ang_q[k] >= LO) && (ang_q[k] <= HI);
    sel[0] = in_win[0];
    sel[1] = in_win[1] && !in_win[0];
    sel[2] = in_win[2] && !(|in_win[1:0]);
    sel[3] = in_win[3] && !(|in_win[2:0]);
    a0 = W'(ang_q[0]);
    a1 = W'(ang_q[1]);
    a2 = W'(ang_q[2]);
    a3 = W'(ang_q[3]);
    y_pos = (ang_q[3] != '0);
    x_pos = (ang_q[0] != '0);
    hit = 1'b1;
    raw = '0;
    // Subtractions are biased by +360 so nothing goes negative.
    unique case (1'b1)
      sel[0]:  raw = y_pos ? a0 : C360 - a0;
      sel[1]:  raw = y_pos ? C540 - a1 : C180 + a1;
      sel[2]:  raw = x_pos ? C270 + a2 : C270 - a2;
      sel[3]:  raw = x_pos ? C450 - a3 : C90 + a3;
      default: hit = 1'b0;
    endcase
    wrap = (raw >= C360) ? raw - C360 : raw;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_theta  <= '0;
      out_miss   <= 1'b0;
      out_stale  <= 1'b0;
      miss_count <= '0;
      last_q     <= '0;
    end else if (state == RESOLVE) begin
      if (hit) begin
        out_theta  <= wrap[OUT_W-1:0];
        last_q     <= wrap[OUT_W-1:0];
        out_miss   <= 1'b0;
        out_stale  <= 1'b0;
        miss_count <= '0;
      end else begin
        out_miss <= 1'b1;
        if (miss_count != '1)
          miss_count <= miss_count + 1'b1;
        if (HOLD_LAST != 0) begin
          out_theta <= last_q;
          out_stale <= 1'b1;
        end else begin
          out_theta <= '1;
          out_stale <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aoa_resolver_seq.sv
// Directed bench: two resolver instances (default, and HOLD_LAST=1,
// LUT_LAT=3, MISS_W=3) each fed by an identity-ROM LUT model.
module tb_aoa_resolver_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       iv, ir, ov, ordy, om, os;
  logic [1:0][31:0] ic;
  logic [1:0][7:0]  lc, lt, mc;
  logic [1:0][8:0]  ot;
  logic [2:0]       mc1;
  logic [7:0]       p1a, p1b;

  assign mc[1] = {5'd0, mc1};

  int total = 0;
  int bad = 0;

  aoa_resolver_seq u0 (
    .clock(clk), .reset_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_codes(ic[0]),
    .lut_code(lc[0]), .lut_theta(lt[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_theta(ot[0]), .out_miss(om[0]),
    .out_stale(os[0]), .miss_count(mc[0])
  );

  aoa_resolver_seq #(
    .LUT_LAT(3), .HOLD_LAST(1), .MISS_W(3)
  ) u1 (
    .clock(clk), .reset_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_codes(ic[1]),
    .lut_code(lc[1]), .lut_theta(lt[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_theta(ot[1]), .out_miss(om[1]),
    .out_stale(os[1]), .miss_count(mc1)
  );

  always_ff @(posedge clk) begin
    lt[0] <= lc[0];
    p1a   <= lc[1];
    p1b   <= p1a;
    lt[1] <= p1b;
  end

  function automatic logic [31:0] pk(
    input int x1, input int x2, input int y1, input int y2);
    return {y2[7:0], y1[7:0], x2[7:0], x1[7:0]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] codes,
                      input int th, input int mi, input int st,
                      input int m, input int lat);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(negedge clk);
    while (!ir[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    ic[d] = codes;
    iv[d] = 1'b1;
    @(posedge clk);
    #1 iv[d] = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1 got = ov[d];
    end
    chk("latency", n, lat);
    chk("theta", int'(ot[d]), th);
    chk("miss", int'(om[d]), mi);
    chk("stale", int'(os[d]), st);
    chk("miss_count", int'(mc[d]), m);
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1 ordy[d] = 1'b0;
    chk("valid_drop", int'(ov[d]), 0);
  endtask

  typedef struct {
    int d;
    logic [31:0] codes;
    int th;
    int mi;
    int st;
    int m;
    int lat;
  } vec_t;

  vec_t tv[13];

  initial begin
    int n, r0, r1, rises;
    bit prev, seen;

    tv[0]  = '{0, pk(60, 0, 0, 10), 60, 0, 0, 0, 6};
    tv[1]  = '{0, pk(60, 0, 0, 0), 300, 0, 0, 0, 6};
    tv[2]  = '{0, pk(0, 50, 0, 5), 130, 0, 0, 0, 6};
    tv[3]  = '{0, pk(20, 0, 90, 0), 0, 0, 0, 0, 6};
    tv[4]  = '{0, pk(0, 0, 0, 0), 511, 1, 0, 1, 6};
    tv[5]  = '{0, pk(0, 0, 0, 0), 511, 1, 0, 2, 6};
    tv[6]  = '{0, pk(10, 0, 0, 70), 20, 0, 0, 0, 6};
    tv[7]  = '{0, pk(0, 0, 0, 45), 135, 0, 0, 0, 6};
    tv[8]  = '{0, pk(91, 90, 39, 0), 270, 0, 0, 0, 6};
    tv[9]  = '{0, pk(40, 0, 0, 0), 320, 0, 0, 0, 6};
    tv[10] = '{0, pk(0, 0, 50, 0), 220, 0, 0, 0, 6};
    tv[11] = '{1, pk(60, 0, 0, 10), 60, 0, 0, 0, 8};
    tv[12] = '{1, pk(0, 0, 0, 0), 60, 1, 1, 1, 8};

    iv = '0;
    ordy = '0;
    ic = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", int'(ov[d]), 0);
      chk("rst_ready", int'(ir[d]), 1);
      chk("rst_theta", int'(ot[d]), 0);
      chk("rst_miss", int'(om[d]), 0);
      chk("rst_stale", int'(os[d]), 0);
      chk("rst_mc", int'(mc[d]), 0);
      chk("rst_lut", int'(lc[d]), 0);
    end
    rst_n = 1'b1;

    foreach (tv[i])
      xfer(tv[i].d, tv[i].codes, tv[i].th, tv[i].mi,
           tv[i].st, tv[i].m, tv[i].lat);

    for (int i = 2; i <= 9; i++)
      xfer(1, pk(0, 0, 0, 0), 60, 1, 1, (i > 7) ? 7 : i, 8);
    xfer(1, pk(60, 0, 0, 10), 60, 0, 0, 0, 8);

    // back-pressure, with a new set offered the whole time
    @(negedge clk);
    ic[0] = pk(60, 0, 0, 10);
    iv[0] = 1'b1;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach", int'(ov[0]), 1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_theta", int'(ot[0]), 60);
      chk("bp_ready", int'(ir[0]), 0);
      chk("bp_mc", int'(mc[0]), 0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    ordy[0] = 1'b0;
    chk("bp_drop", int'(ov[0]), 0);
    chk("bp_ready_after", int'(ir[0]), 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (ov[0] || !ir[0]) seen = 1;
    end
    chk("bp_no_accept", int'(seen), 0);

    // back-to-back period
    @(negedge clk);
    ic[0] = pk(0, 50, 0, 5);
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    prev = 0;
    rises = 0;
    r0 = 0;
    r1 = 0;
    for (int c = 0; c < 40 && rises < 2; c++) begin
      @(posedge clk);
      #1 if (ov[0] && !prev) begin
        if (rises == 0) r0 = c;
        else r1 = c;
        rises++;
      end
      prev = ov[0];
    end
    chk("b2b_rises", rises, 2);
    chk("b2b_period", r1 - r0, 8);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;

    xfer(0, pk(0, 0, 0, 0), 511, 1, 0, 1, 6);

    // reset in the second LOOKUP cycle
    @(negedge clk);
    ic[0] = pk(60, 0, 0, 10);
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    #1 chk("ab_lut_x2", int'(lc[0]), 0);
    chk("ab_busy", int'(ir[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("ab_valid", int'(ov[0]), 0);
    chk("ab_ready", int'(ir[0]), 1);
    chk("ab_theta", int'(ot[0]), 0);
    chk("ab_miss", int'(om[0]), 0);
    chk("ab_mc", int'(mc[0]), 0);
    chk("ab_lut", int'(lc[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (ov[0]) seen = 1;
    end
    chk("ab_no_valid", int'(seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
